video_filter_coe_ctrl: RTL and testbench
========================================

Name: video_filter_coe_ctrl

Overview:
- Run-time configuration controller for the convolution filter's coefficient matrix and normalisation factor.
- Software writes a shadow bank through a simple register port and requests a commit. The block copies shadow to the active bank only on a start-of-frame handshake, so a frame is never filtered with mixed coefficients.
- Sits beside the filter and snoops the filter's input AXI4-Stream video handshake. It drives the filter's coefficient and normalisation inputs.

Parameters:
FILTER_DIM, 3, kernel is FILTER_DIM x FILTER_DIM
COE_WIDTH, 8, signed coefficient width
NORM_WIDTH, 24, unsigned normalisation factor width; filter output = sum * norm / 2^16
NORM_DEFAULT, 65536, reset value of norm; gives unity gain
ADDR_WIDTH, 5, config address width; must satisfy 2^ADDR_WIDTH > FILTER_DIM^2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  ADDR_WIDTH  write address
cfg_wdata  in  32  write data
cfg_commit  in  1  request shadow-to-active swap at next SOF
cfg_busy  out  1  high while a commit is pending
cfg_err  out  1  one-cycle pulse on a rejected write
video_tvalid  in  1  snooped filter input tvalid
video_tready  in  1  snooped filter input tready
video_tuser  in  1  snooped filter input tuser (SOF)
coe_flat  out  FILTER_DIM*FILTER_DIM*COE_WIDTH  active coefficients
norm_factor  out  NORM_WIDTH  active normalisation factor
swap_pulse  out  1  one-cycle pulse after an active-bank update
frame_cnt  out  16  count of SOF beats, wraps

Behaviour:
- Clock and reset: clk, all logic on posedge; reset is synchronous and active-low.
- Address map:
  - addr k for 0 <= k < FILTER_DIM^2: coefficient [k / FILTER_DIM][k % FILTER_DIM], row-major, data cfg_wdata[COE_WIDTH-1:0].
  - addr FILTER_DIM^2: norm, data cfg_wdata[NORM_WIDTH-1:0].
  - Any other address: write rejected, cfg_err pulses.
- coe_flat packing: entry k occupies bits [k*COE_WIDTH +: COE_WIDTH].
- SOF beat is defined as video_tvalid & video_tready & video_tuser.
- Reset values:
  - Active and shadow coefficients: all 0 except centre [FILTER_DIM/2][FILTER_DIM/2] = 1.
  - Active and shadow norm: NORM_DEFAULT.
  - state = IDLE.
  - cfg_busy = 0, cfg_err = 0, swap_pulse = 0, frame_cnt = 0.
- FSM states: IDLE, DIRTY, PENDING.
  - IDLE: a valid write updates shadow -> DIRTY. cfg_commit alone is a no-op: no swap, no pulse.
  - DIRTY: valid writes update shadow, stay DIRTY. cfg_commit -> PENDING.
  - PENDING: cfg_busy = 1. Any cfg_we is rejected: shadow unchanged, cfg_err pulses. On an SOF beat, active <= shadow on that same edge, state -> IDLE, and swap_pulse = 1 on the following cycle.
- Latency: an SOF beat at edge n makes new coe_flat/norm_factor visible after edge n. The filter's first-pixel multiply stage therefore sees the new values.
- Simultaneous events:
  - cfg_we and cfg_commit in DIRTY or IDLE: the write lands first, then the commit applies. From IDLE this goes directly to PENDING.
  - cfg_commit and an SOF beat in the same cycle in DIRTY: no swap this frame; the swap happens at the next SOF.
  - cfg_commit while PENDING: ignored.
- frame_cnt increments on every SOF beat in every state and wraps 0xFFFF -> 0.
- Reset mid-PENDING: the pending commit is discarded and both banks return to reset values.
- cfg_err and swap_pulse are registered outputs. cfg_busy is decoded from state.

Decomposition:
- Shared package video_filter_pkg:
  - FSM state encoding (one-hot).
  - Address constants COE_BASE = 0 and NORM_ADDR = FILTER_DIM^2.
  - Identity-kernel helper function.
  - Default NORM_DEFAULT.
- One sub-module, video_filter_coe_bank: register array with write-enable and parallel load, instantiated twice (shadow, active). The FSM lives in the top module.

Test Plan:
- Reset, then check outputs -> coe_flat centre entry = 1, others 0; norm_factor = 65536; cfg_busy = 0; frame_cnt = 0.
- Write addr 0..8 = 0x01..0x09 and addr 9 = 0x1C72, commit, then drive an SOF beat -> active unchanged until that edge; afterwards coe entry 4 = 0x05, norm = 0x1C72; swap_pulse high exactly one cycle; cfg_busy falls.
- While PENDING, write addr 3 = 0x7F -> cfg_err one-cycle pulse; after swap, entry 3 still holds the pre-commit value.
- Commit in IDLE with no prior writes, then an SOF beat -> no swap_pulse, state stays IDLE.
- cfg_commit and SOF beat in the same cycle from DIRTY -> no swap; swap occurs at the second SOF; frame_cnt = 2.
- SOF beat with video_tready = 0 -> not counted, no swap; an SOF at frame_cnt = 0xFFFF -> wraps to 0. Reset asserted during PENDING -> identity kernel restored, busy = 0.

Source files
------------

// File: rtl/video_filter_pkg.sv
// rtl/video_filter_pkg.sv - shared types, address constants and kernel helpers for the coefficient controller
package video_filter_pkg;

    // One-hot commit state: cfg_busy is simply the PENDING bit
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_DIRTY   = 3'b010,
        ST_PENDING = 3'b100
    } state_t;

    localparam int DEF_FILTER_DIM   = 3;
    localparam int COE_BASE         = 0;
    localparam int NORM_ADDR        = DEF_FILTER_DIM * DEF_FILTER_DIM;
    localparam int NORM_DEFAULT_VAL = 65536;

    function automatic int norm_addr(input int dim);
        return dim * dim;
    endfunction

    // True for the kernel centre tap, the only non-zero entry of an identity kernel
    function automatic bit is_identity_centre(input int k, input int dim);
        return k == ((dim / 2) * dim + (dim / 2));
    endfunction

endpackage

// File: rtl/video_filter_coe_ctrl_if.sv
// rtl/video_filter_coe_ctrl_if.sv - config register port and snooped video handshake bundle
interface video_filter_coe_ctrl_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  cfg_we;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [31:0]           cfg_wdata;
    logic                  cfg_commit;
    logic                  cfg_busy;
    logic                  cfg_err;
    logic                  video_tvalid;
    logic                  video_tready;
    logic                  video_tuser;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        output video_tvalid, video_tready, video_tuser,
        input  cfg_busy, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        input  video_tvalid, video_tready, video_tuser,
        output cfg_busy, cfg_err
    );
endinterface

// File: rtl/video_filter_coe_bank.sv
// rtl/video_filter_coe_bank.sv - coefficient/norm register bank with addressed write and parallel load
module video_filter_coe_bank
    import video_filter_pkg::*;
#(
    parameter int FILTER_DIM   = 3,
    parameter int COE_WIDTH    = 8,
    parameter int NORM_WIDTH   = 24,
    parameter int NORM_DEFAULT = NORM_DEFAULT_VAL,
    parameter int ADDR_WIDTH   = 5,
    localparam int N  = FILTER_DIM * FILTER_DIM,
    localparam int FW = N * COE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  load,
    input  logic [FW-1:0]         load_coe,
    input  logic [NORM_WIDTH-1:0] load_norm,
    output logic [FW-1:0]         coe_flat,
    output logic [NORM_WIDTH-1:0] norm
);

    localparam logic [ADDR_WIDTH-1:0] NORM_A = ADDR_WIDTH'(norm_addr(FILTER_DIM));

    logic [COE_WIDTH-1:0] coe [N];

    // Upper data bits beyond the widest field are intentionally ignored
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N; k++)
                coe[k] <= COE_WIDTH'(is_identity_centre(k, FILTER_DIM));
            norm <= NORM_WIDTH'(NORM_DEFAULT);
        end else if (load) begin
            for (int k = 0; k < N; k++)
                coe[k] <= load_coe[k*COE_WIDTH +: COE_WIDTH];
            norm <= load_norm;
        end else if (we) begin
            for (int k = 0; k < N; k++)
                if (waddr == ADDR_WIDTH'(COE_BASE + k))
                    coe[k] <= wdata[COE_WIDTH-1:0];
            if (waddr == NORM_A)
                norm <= wdata[NORM_WIDTH-1:0];
        end
    end

    always_comb begin
        coe_flat = '0;
        for (int k = 0; k < N; k++)
            coe_flat[k*COE_WIDTH +: COE_WIDTH] = coe[k];
    end

endmodule

// File: rtl/video_filter_coe_ctrl.sv
// rtl/video_filter_coe_ctrl.sv - frame-synchronous shadow/active coefficient controller for the convolution filter
module video_filter_coe_ctrl
    import video_filter_pkg::*;
#(
    parameter int FILTER_DIM   = 3,
    parameter int COE_WIDTH    = 8,
    parameter int NORM_WIDTH   = 24,
    parameter int NORM_DEFAULT = NORM_DEFAULT_VAL,
    parameter int ADDR_WIDTH   = 5,
    localparam int N  = FILTER_DIM * FILTER_DIM,
    localparam int FW = N * COE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    video_filter_coe_ctrl_if.slave    bus,
    output logic [FW-1:0]             coe_flat,
    output logic [NORM_WIDTH-1:0]     norm_factor,
    output logic                      swap_pulse,
    output logic [15:0]               frame_cnt
);

    localparam logic [ADDR_WIDTH-1:0] NORM_A = ADDR_WIDTH'(norm_addr(FILTER_DIM));

    state_t state, state_next;
    logic   sof;
    logic   addr_ok;
    logic   shadow_we;
    logic   load_active;
    logic   err_next;
    logic   swap_next;
    logic   err_q;

    logic [FW-1:0]         shadow_coe;
    logic [NORM_WIDTH-1:0] shadow_norm;

    assign sof     = bus.video_tvalid & bus.video_tready & bus.video_tuser;
    assign addr_ok = (bus.cfg_addr <= NORM_A);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            err_q      <= 1'b0;
            swap_pulse <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            state      <= state_next;
            err_q      <= err_next;
            swap_pulse <= swap_next;
            if (sof)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // A write landing in the same cycle as a commit counts, so IDLE can jump straight to PENDING
    always_comb begin
        state_next  = state;
        shadow_we   = 1'b0;
        load_active = 1'b0;
        err_next    = 1'b0;
        swap_next   = 1'b0;
        case (state)
            ST_IDLE, ST_DIRTY: begin
                if (bus.cfg_we) begin
                    if (addr_ok) begin
                        shadow_we  = 1'b1;
                        state_next = ST_DIRTY;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                if (bus.cfg_commit && (state == ST_DIRTY || shadow_we))
                    state_next = ST_PENDING;
            end
            ST_PENDING: begin
                err_next = bus.cfg_we;
                if (sof) begin
                    load_active = 1'b1;
                    swap_next   = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.cfg_busy = (state == ST_PENDING);
    assign bus.cfg_err  = err_q;

    video_filter_coe_bank #(
        .FILTER_DIM  (FILTER_DIM),
        .COE_WIDTH   (COE_WIDTH),
        .NORM_WIDTH  (NORM_WIDTH),
        .NORM_DEFAULT(NORM_DEFAULT),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .we       (shadow_we),
        .waddr    (bus.cfg_addr),
        .wdata    (bus.cfg_wdata),
        .load     (1'b0),
        .load_coe ('0),
        .load_norm('0),
        .coe_flat (shadow_coe),
        .norm     (shadow_norm)
    );

    // The active bank only ever takes a whole-bank copy, never a partial write
    video_filter_coe_bank #(
        .FILTER_DIM  (FILTER_DIM),
        .COE_WIDTH   (COE_WIDTH),
        .NORM_WIDTH  (NORM_WIDTH),
        .NORM_DEFAULT(NORM_DEFAULT),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_active (
        .clk      (clk),
        .reset    (reset),
        .we       (1'b0),
        .waddr    (bus.cfg_addr),
        .wdata    (bus.cfg_wdata),
        .load     (load_active),
        .load_coe (shadow_coe),
        .load_norm(shadow_norm),
        .coe_flat (coe_flat),
        .norm     (norm_factor)
    );

endmodule

// File: tb/tb_video_filter_coe_ctrl.sv
// tb/tb_video_filter_coe_ctrl.sv - self-checking bench for the coefficient controller
module tb_video_filter_coe_ctrl;

    logic        clk;
    logic        reset;
    logic [71:0] coe_flat;
    logic [23:0] norm_factor;
    logic        swap_pulse;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    video_filter_coe_ctrl_if #(.ADDR_WIDTH(5)) bus ();

    video_filter_coe_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .coe_flat   (coe_flat),
        .norm_factor(norm_factor),
        .swap_pulse (swap_pulse),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: two banks plus "has uncommitted edits" and "waiting for a frame" flags
    logic [7:0]  sh_coe [9];
    logic [7:0]  ac_coe [9];
    logic [23:0] sh_norm, ac_norm;
    bit          m_dirty, m_pending, m_err, m_swap;
    logic [15:0] m_frame;

    function automatic logic [71:0] m_flat();
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = ac_coe[k];
        return r;
    endfunction

    function automatic logic [71:0] identity_flat();
        logic [71:0] r;
        r = '0;
        r[4*8 +: 8] = 8'd1;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) begin
            sh_coe[k] = (k == 4) ? 8'd1 : 8'd0;
            ac_coe[k] = sh_coe[k];
        end
        sh_norm = 24'd65536; ac_norm = 24'd65536;
        m_dirty = 0; m_pending = 0; m_err = 0; m_swap = 0; m_frame = 16'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.cfg_commit = 0;
        bus.video_tvalid = 0; bus.video_tready = 0; bus.video_tuser = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic cycle(input bit we, input int addr, input logic [31:0] data,
                         input bit commit, input bit tv, input bit tr, input bit tu);
        bit sof;
        @(negedge clk);
        bus.cfg_we = we; bus.cfg_addr = 5'(addr); bus.cfg_wdata = data; bus.cfg_commit = commit;
        bus.video_tvalid = tv; bus.video_tready = tr; bus.video_tuser = tu;
        @(posedge clk);
        sof = tv & tr & tu;
        m_err = 0; m_swap = 0;
        if (m_pending) begin
            m_err = we;
            if (sof) begin
                for (int k = 0; k < 9; k++) ac_coe[k] = sh_coe[k];
                ac_norm = sh_norm; m_pending = 0; m_swap = 1;
            end
        end else begin
            if (we && addr <= 9) begin
                if (addr < 9) sh_coe[addr] = data[7:0];
                else sh_norm = data[23:0];
                m_dirty = 1;
            end else if (we) begin
                m_err = 1;
            end
            if (commit && m_dirty) begin m_pending = 1; m_dirty = 0; end
        end
        if (sof) m_frame = m_frame + 16'd1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (coe_flat !== identity_flat()) begin bad++; $display("FAIL reset_coe got=%h exp=%h", coe_flat, identity_flat()); end
        total++; if (norm_factor !== 24'd65536) begin bad++; $display("FAIL reset_norm got=%0d exp=65536", norm_factor); end
        total++; if (bus.cfg_busy !== 1'b0 || bus.cfg_err !== 1'b0 || swap_pulse !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b err=%b swap=%b exp=000", bus.cfg_busy, bus.cfg_err, swap_pulse); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame got=%0d exp=0", frame_cnt); end
    endtask

    task automatic test_commit_swap();
        apply_reset();
        for (int k = 0; k < 9; k++) cycle(1, k, 32'(k + 1), 0, 0, 0, 0);
        cycle(1, 9, 32'h1C72, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        total++; if (coe_flat !== identity_flat() || norm_factor !== 24'd65536) begin bad++; $display("FAIL swap_before coe=%h norm=%h exp identity/65536", coe_flat, norm_factor); end
        total++; if (bus.cfg_busy !== 1'b1) begin bad++; $display("FAIL swap_busy got=%b exp=1", bus.cfg_busy); end
        cycle(0, 0, 0, 0, 1, 1, 1);
        total++; if (coe_flat[4*8 +: 8] !== 8'h05 || coe_flat[8*8 +: 8] !== 8'h09 || norm_factor !== 24'h1C72) begin bad++; $display("FAIL swap_after coe=%h norm=%h exp e4=05 e8=09 norm=1c72", coe_flat, norm_factor); end
        total++; if (swap_pulse !== 1'b1 || bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL swap_pulse swap=%b busy=%b exp 1/0", swap_pulse, bus.cfg_busy); end
        cycle(0, 0, 0, 0, 0, 0, 0);
        total++; if (swap_pulse !== 1'b0) begin bad++; $display("FAIL swap_one_cycle got=%b exp=0", swap_pulse); end
    endtask

    task automatic test_pending_reject();
        cycle(1, 3, 32'h33, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(1, 3, 32'h7F, 0, 0, 0, 0);
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL reject_err got=%b exp=1", bus.cfg_err); end
        cycle(0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL reject_err_pulse got=%b exp=0", bus.cfg_err); end
        cycle(0, 0, 0, 0, 1, 1, 1);
        total++; if (coe_flat[3*8 +: 8] !== 8'h33) begin bad++; $display("FAIL reject_keep got=%h exp=33", coe_flat[3*8 +: 8]); end
        cycle(1, 20, 32'h1, 0, 0, 0, 0);
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL bad_addr_err got=%b exp=1", bus.cfg_err); end
    endtask

    task automatic test_idle_commit();
        apply_reset();
        cycle(0, 0, 0, 1, 0, 0, 0);
        total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL idle_commit_busy got=%b exp=0", bus.cfg_busy); end
        cycle(0, 0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        total++; if (swap_pulse !== 1'b0 || coe_flat !== identity_flat()) begin bad++; $display("FAIL idle_commit_noswap swap=%b coe=%h exp 0/identity", swap_pulse, coe_flat); end
    endtask

    task automatic test_commit_sof_same();
        apply_reset();
        cycle(1, 0, 32'h11, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        total++; if (swap_pulse !== 1'b0 || coe_flat[7:0] !== 8'h00 || bus.cfg_busy !== 1'b1) begin bad++; $display("FAIL same_cycle swap=%b e0=%h busy=%b exp 0/00/1", swap_pulse, coe_flat[7:0], bus.cfg_busy); end
        cycle(0, 0, 0, 0, 1, 1, 1);
        total++; if (swap_pulse !== 1'b1 || coe_flat[7:0] !== 8'h11 || frame_cnt !== 16'd2) begin bad++; $display("FAIL second_sof swap=%b e0=%h frame=%0d exp 1/11/2", swap_pulse, coe_flat[7:0], frame_cnt); end
    endtask

    task automatic test_tready_low_wrap();
        apply_reset();
        cycle(1, 9, 32'h4000, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 1);
        total++; if (frame_cnt !== 16'd0 || bus.cfg_busy !== 1'b1 || norm_factor !== 24'd65536) begin bad++; $display("FAIL tready_low frame=%0d busy=%b norm=%h exp 0/1/10000", frame_cnt, bus.cfg_busy, norm_factor); end
        for (int i = 0; i < 65535; i++) cycle(0, 0, 0, 0, 1, 1, 1);
        total++; if (frame_cnt !== 16'hFFFF || norm_factor !== 24'h4000) begin bad++; $display("FAIL frame_max frame=%h norm=%h exp ffff/4000", frame_cnt, norm_factor); end
        cycle(0, 0, 0, 0, 1, 1, 1);
        total++; if (frame_cnt !== 16'h0000) begin bad++; $display("FAIL frame_wrap got=%h exp=0000", frame_cnt); end
    endtask

    task automatic test_reset_pending();
        cycle(1, 4, 32'h22, 1, 0, 0, 0);
        total++; if (bus.cfg_busy !== 1'b1) begin bad++; $display("FAIL rst_pend_setup busy=%b exp=1", bus.cfg_busy); end
        apply_reset();
        cycle(0, 0, 0, 0, 1, 1, 1);
        total++; if (coe_flat !== identity_flat() || bus.cfg_busy !== 1'b0 || swap_pulse !== 1'b0) begin bad++; $display("FAIL rst_pend coe=%h busy=%b swap=%b exp identity/0/0", coe_flat, bus.cfg_busy, swap_pulse); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 2) == 0), int'($urandom_range(0, 12)), $urandom,
                  ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
            total++;
            if (coe_flat !== m_flat() || norm_factor !== ac_norm || bus.cfg_busy !== m_pending ||
                bus.cfg_err !== m_err || swap_pulse !== m_swap || frame_cnt !== m_frame) begin
                bad++;
                $display("FAIL random[%0d] coe=%h/%h norm=%h/%h busy=%b/%b err=%b/%b swap=%b/%b frame=%0d/%0d",
                         i, coe_flat, m_flat(), norm_factor, ac_norm, bus.cfg_busy, m_pending,
                         bus.cfg_err, m_err, swap_pulse, m_swap, frame_cnt, m_frame);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.cfg_commit = 0;
        bus.video_tvalid = 0; bus.video_tready = 0; bus.video_tuser = 0;
        model_reset();
        test_reset();
        test_commit_swap();
        test_pending_reject();
        test_idle_commit();
        test_commit_sof_same();
        test_tready_low_wrap();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
